// File: rtl/pwm_pkg.sv
// Shared widths, direction encoding and the counter step rule for the PWM timebase.
package pwm_pkg;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned PRE_W = 8;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // One tick of the up/down counter with wrap inside 0..period; an out-of-range
   // count (period lowered below it) is pulled back into range on the next tick.
   function automatic logic [CNT_W-1:0] step_count(input logic [CNT_W-1:0] cnt,
                                                   input logic [CNT_W-1:0] period,
                                                   input dir_e             dir);
      logic [CNT_W-1:0] nxt;
      nxt = cnt;
      if (dir == DIR_UP) begin
         if (cnt >= period) begin
            nxt = '0;
         end else begin
            nxt = cnt + CNT_W'(1);
         end
      end else begin
         if ((cnt == '0) || (cnt > period)) begin
            nxt = period;
         end else begin
            nxt = cnt - CNT_W'(1);
         end
      end
      return nxt;
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: asserts tick on every (prescale+1)-th cycle while not cleared.
module pwm_prescaler
   import pwm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [PRE_W-1:0] prescale,
   output logic             tick
);

   logic [PRE_W-1:0] pre_cnt_q;
   logic [PRE_W-1:0] pre_cnt_d;

   // >= rather than == so that lowering prescale mid-run cannot strand the counter.
   always_comb begin
      tick      = 1'b0;
      pre_cnt_d = pre_cnt_q;
      if (clr) begin
         pre_cnt_d = '0;
      end else if (pre_cnt_q >= prescale) begin
         tick      = 1'b1;
         pre_cnt_d = '0;
      end else begin
         pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

endmodule

// File: rtl/pwm_counter.sv
// Programmable up/down PWM timebase: prescaled 16-bit counter wrapping inside 0..period.
module pwm_counter
   import pwm_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             count_reset,
   input  logic             upnotdown,
   input  logic [PRE_W-1:0] prescale,
   input  logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] count_val
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             pre_clr;
   logic             tick;

   // Disabling clears the prescaler so a re-enable always waits a full prescale period.
   assign pre_clr = count_reset | ~en;

   pwm_prescaler u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (pre_clr),
      .prescale (prescale),
      .tick     (tick)
   );

   always_comb begin
      cnt_d = cnt_q;
      if (count_reset) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = step_count(cnt_q, period, dir_e'(upnotdown));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_val = cnt_q;

endmodule

// File: tb/tb_pwm_counter.sv
// Self-checking bench for pwm_counter: vector table, directed corner sequences, random stress.
module tb_pwm_counter;
   import pwm_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic             count_reset;
   logic             upnotdown;
   logic [PRE_W-1:0] prescale;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] count_val;

   int n_checks = 0;
   int n_fail   = 0;

   logic [CNT_W-1:0] exp_q[$];
   logic [CNT_W-1:0] m_cnt = '0;
   logic [PRE_W-1:0] m_pre = '0;

   typedef struct {
      logic             rst_n;
      logic             count_reset;
      logic             en;
      logic             up;
      logic [PRE_W-1:0] prescale;
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] exp;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   pwm_counter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .count_reset (count_reset),
      .upnotdown   (upnotdown),
      .prescale    (prescale),
      .period      (period),
      .count_val   (count_val)
   );

   function automatic void check(input string name, input logic [CNT_W-1:0] act,
                                 input logic [CNT_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: count_val=%0d required=%0d", name, act, exp);
      end
   endfunction

   function automatic vec_t mk(input logic r, input logic cr, input logic e, input logic u,
                               input int pre, input int per, input int exp);
      vec_t v;
      v.rst_n       = r;
      v.count_reset = cr;
      v.en          = e;
      v.up          = u;
      v.prescale    = PRE_W'(pre);
      v.period      = CNT_W'(per);
      v.exp         = CNT_W'(exp);
      return v;
   endfunction

   task automatic drive(input logic r, input logic cr, input logic e, input logic u,
                        input int pre, input int per);
      rst_n       = r;
      count_reset = cr;
      en          = e;
      upnotdown   = u;
      prescale    = PRE_W'(pre);
      period      = CNT_W'(per);
   endtask

   // Behavioural reference for one rising edge, evaluated on the inputs about to be sampled.
   task automatic model_edge();
      if (!rst_n) begin
         m_cnt = '0;
         m_pre = '0;
      end else if (count_reset) begin
         m_cnt = '0;
         m_pre = '0;
      end else if (!en) begin
         m_pre = '0;
      end else if (m_pre < prescale) begin
         m_pre = m_pre + 1'b1;
      end else begin
         m_pre = '0;
         if (upnotdown) begin
            m_cnt = (m_cnt >= period) ? '0 : m_cnt + 1'b1;
         end else begin
            m_cnt = ((m_cnt == '0) || (m_cnt > period)) ? period : m_cnt - 1'b1;
         end
      end
   endtask

   task automatic step(input string name);
      logic [CNT_W-1:0] e;
      model_edge();
      exp_q.push_back(m_cnt);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, count_val=%0d required=none", name, count_val);
      end else begin
         e = exp_q.pop_front();
         check(name, count_val, e);
      end
   endtask

   task automatic step_exp(input string name, input int exp);
      step(name);
      check({name, "_const"}, count_val, CNT_W'(exp));
   endtask

   initial begin
      logic [CNT_W-1:0] frozen;
      logic [CNT_W-1:0] prev;
      logic [CNT_W-1:0] bound;

      drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 10);

      // Reset, count up 1..10 then wrap, then count down from 0 through 10..0 and wrap.
      for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 1, 0, 10, 0));
      for (int i = 1; i <= 10; i++) vecs.push_back(mk(1, 0, 1, 1, 0, 10, i));
      vecs.push_back(mk(1, 0, 1, 1, 0, 10, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 10, 10));
      for (int i = 9; i >= 0; i--) vecs.push_back(mk(1, 0, 1, 0, 0, 10, i));
      vecs.push_back(mk(1, 0, 1, 0, 0, 10, 10));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst_n, vecs[i].count_reset, vecs[i].en, vecs[i].up,
               int'(vecs[i].prescale), int'(vecs[i].period));
         step_exp($sformatf("vec%0d", i), int'(vecs[i].exp));
      end

      // Prescale 5 then 20: first step on edge prescale+1 after a clear.
      drive(1, 1, 1, 1, 5, 10);
      step_exp("pre5_clr", 0);
      drive(1, 0, 1, 1, 5, 10);
      for (int i = 1; i <= 5; i++) step_exp($sformatf("pre5_hold%0d", i), 0);
      step_exp("pre5_tick", 1);
      drive(1, 1, 1, 1, 20, 10);
      step_exp("pre20_clr", 0);
      drive(1, 0, 1, 1, 20, 10);
      for (int i = 1; i <= 20; i++) step("pre20_hold");
      check("pre20_hold_last", count_val, 0);
      step_exp("pre20_tick", 1);

      // Freeze: run, disable for 30 cycles, re-enable for 7 cycles.
      drive(1, 1, 1, 1, 5, 10);
      step_exp("frz_clr", 0);
      drive(1, 0, 1, 1, 5, 10);
      for (int i = 0; i < 20; i++) step("frz_run");
      check("frz_run_val", count_val, 3);
      frozen = m_cnt;
      drive(1, 0, 0, 1, 5, 10);
      for (int i = 0; i < 30; i++) begin
         step("frz_off");
         check("frz_hold", count_val, frozen);
      end
      drive(1, 0, 1, 1, 5, 10);
      for (int i = 0; i < 7; i++) step("frz_on");
      check("frz_resume", count_val, (frozen == 10) ? '0 : frozen + 1'b1);

      // Period 4 wrap after clear.
      drive(1, 1, 1, 1, 0, 4);
      step_exp("p4_clr", 0);
      drive(1, 0, 1, 1, 0, 4);
      for (int i = 1; i <= 4; i++) step_exp($sformatf("p4_up%0d", i), i);
      step_exp("p4_wrap", 0);

      // Direction flip takes effect on the next tick.
      drive(1, 1, 1, 1, 0, 10);
      step_exp("flip_clr", 0);
      drive(1, 0, 1, 1, 0, 10);
      step_exp("flip_up", 1);
      drive(1, 0, 1, 0, 0, 10);
      step_exp("flip_down", 0);

      // Period 0 pins the counter at 0 in either direction.
      drive(1, 0, 1, 1, 0, 0);
      for (int i = 0; i < 10; i++) step_exp("p0_up", 0);
      drive(1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) step_exp("p0_down", 0);

      // Lowering period below the count: up wraps to 0, down snaps to period.
      drive(1, 0, 1, 1, 0, 10);
      for (int i = 1; i <= 8; i++) step_exp("shrink_up_run", i);
      drive(1, 0, 1, 1, 0, 5);
      step_exp("shrink_up_wrap", 0);
      drive(1, 0, 1, 1, 0, 10);
      for (int i = 1; i <= 8; i++) step_exp("shrink_dn_run", i);
      drive(1, 0, 1, 0, 0, 5);
      step_exp("shrink_dn_snap", 5);

      // Random stress against the reference model and the range bound.
      for (int i = 0; i < 200; i++) begin
         drive(1, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) != 0),
               $urandom_range(0, 1), $urandom_range(0, 10), $urandom_range(0, 20));
         prev  = m_cnt;
         bound = (period > prev) ? period : prev;
         step($sformatf("rand%0d", i));
         n_checks++;
         if (count_val > bound) begin
            n_fail++;
            $display("FAIL rand_bound%0d: count_val=%0d required<=%0d", i, count_val, bound);
         end
      end

      // Reset mid-run returns to 0 on the sampling edge.
      drive(1, 0, 1, 1, 0, 10);
      for (int i = 0; i < 3; i++) step("pre_rst_run");
      drive(0, 0, 1, 1, 0, 10);
      step_exp("mid_rst", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required=finish");
      $fatal(1, "watchdog");
   end

endmodule
